// File: rtl/sync_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sync_debounce_pkg
// Purpose : Shared types and constants for the sync_debounce input
//           conditioning stage: FSM state encoding, glitch counter width
//           and default parameter values.
// Ports   : none (package)
// Config  : SYNC_DEBOUNCE_GLITCH_CNT_EN (consumed by sync_debounce)
// Revision: 1.0 - initial release
// ============================================================================
package sync_debounce_pkg;

  // Width of the optional aborted-check counter and its saturation value.
  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] c_GLITCH_MAX = {GLITCH_W{1'b1}};

  // Default parameter values for the top level.
  localparam int c_SYNC_STAGES_DEFAULT = 2;
  localparam int c_HOLD_DEFAULT        = 16;
  localparam int c_CNT_W_DEFAULT       = 8;

  // Debounce FSM. The IDLE_* states carry the committed level; the CHK_*
  // states are qualifying a move towards the level named in the state.
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  // True while a transition is being qualified.
  function automatic logic is_check(input state_t st);
    return (st == CHK_HI) || (st == CHK_LO);
  endfunction

endpackage : sync_debounce_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module  : sync_chain
// Purpose : Multi-flop synchroniser for a single asynchronous level. Shifts
//           on every rising clock edge; there is deliberately no enable so
//           metastability settling is never stalled.
// Ports   : clk  in  1  clock
//           clr  in  1  asynchronous reset, active low (chain clears to 0)
//           d    in  1  asynchronous input level
//           q    out 1  synchronised level (last stage)
// Revision: 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Stage 0 captures the raw input; each later stage copies its predecessor.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module  : sync_debounce
// Purpose : Synchronise, debounce and edge-detect an asynchronous level.
//           A new level is committed on the HOLD-th consecutive enabled
//           edge that samples it; any reversal in between aborts the check.
// Ports   : clk         in  1  clock, rising edge
//           clr         in  1  asynchronous reset, active low
//           en          in  1  qualification enable (FSM/counter hold at 0)
//           din         in  1  raw asynchronous input
//           level       out 1  debounced level
//           rise        out 1  one-cycle pulse on committed 0->1
//           fall        out 1  one-cycle pulse on committed 1->0
//           busy        out 1  high while a transition is being qualified
//           glitch_cnt  out 8  saturating aborted-check count (optional)
// Config  : SYNC_DEBOUNCE_GLITCH_CNT_EN - when defined, adds glitch_cnt
// Revision: 1.0 - initial release
// ============================================================================
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT,
  parameter int HOLD        = c_HOLD_DEFAULT,
  parameter int CNT_W       = c_CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic                din,
  output logic                level,
  output logic                rise,
  output logic                fall,
  output logic                busy
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  // Count value at which the next matching sample commits the new level.
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic w_s;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk (clk),
    .clr (clr),
    .d   (din),
    .q   (w_s)
  );

  // --------------------------------------------------------------------------
  // FSM, counter and output registers
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Everything holds while en is low, except the strobes, which default to
  // 0 so that each pulse lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;

    if (en) begin
      case (r_state)
        IDLE_LO: begin
          // The starting edge already counts as the first matching sample.
          if (w_s) begin
            w_state_nxt = CHK_HI;
            w_cnt_nxt   = c_CNT_ONE;
          end
        end

        CHK_HI: begin
          if (!w_s) begin
            w_state_nxt = IDLE_LO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_HOLD_LAST) begin
            w_state_nxt = IDLE_HI;
            w_level_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end

        IDLE_HI: begin
          if (!w_s) begin
            w_state_nxt = CHK_LO;
            w_cnt_nxt   = c_CNT_ONE;
          end
        end

        CHK_LO: begin
          if (w_s) begin
            w_state_nxt = IDLE_HI;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_HOLD_LAST) begin
            w_state_nxt = IDLE_LO;
            w_level_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end

        default: begin
          w_state_nxt = IDLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end
      endcase
    end

    // busy is registered from the next state so it tracks the FSM exactly.
    w_busy_nxt = is_check(w_state_nxt);
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign busy  = r_busy;

  // --------------------------------------------------------------------------
  // Optional aborted-check counter
  // --------------------------------------------------------------------------
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic                w_abort;
  logic [GLITCH_W-1:0] r_glitch_cnt;

  // An abort is a CHK state seeing the level it started from on an
  // enabled edge, i.e. the CHK -> IDLE return without a commit.
  assign w_abort = en && (((r_state == CHK_HI) && !w_s) ||
                          ((r_state == CHK_LO) &&  w_s));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_glitch_cnt <= '0;
    end else if (w_abort && (r_glitch_cnt != c_GLITCH_MAX)) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule : sync_debounce
`default_nettype wire
